// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian 32-bit words to
// instruction memory from address 0, and releases the core after a good checksum.
//
// state  | meaning
// IDLE   | waiting for MAGIC; non-MAGIC bytes dropped
// CNT_H  | expecting high byte of the word count
// CNT_L  | expecting low byte of the word count
// DATA   | assembling data words and writing them to memory
// CSUM   | expecting the XOR checksum byte
// RUN    | frame accepted, core running; MAGIC starts a reload
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_wena,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_DATA, S_CSUM, S_RUN
  } state_t;

  localparam logic [16:0]         MAX_WORDS = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);

  state_t                r_state, w_state_nx;
  logic [7:0]            r_cnt_hi, w_cnt_hi_nx;
  logic [ADDR_WIDTH:0]   r_words_left, w_words_left_nx;
  logic [ADDR_WIDTH:0]   r_word_idx, w_word_idx_nx;
  logic [1:0]            r_byte_idx, w_byte_idx_nx;
  logic [23:0]           r_asm, w_asm_nx;
  logic [7:0]            r_csum, w_csum_nx;
  logic                  r_rx_ready;
  logic                  r_wena, w_wena_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic [31:0]           r_wdata, w_wdata_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;
  logic                  r_cpu_rst_n, w_cpu_rst_n_nx;
  logic                  r_error, w_error_nx;
  logic                  w_accept;
  logic [15:0]           w_count;

  assign w_accept = rx_valid & r_rx_ready;
  assign w_count  = {r_cnt_hi, rx_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_hi_nx     = r_cnt_hi;
    w_words_left_nx = r_words_left;
    w_word_idx_nx   = r_word_idx;
    w_byte_idx_nx   = r_byte_idx;
    w_asm_nx        = r_asm;
    w_csum_nx       = r_csum;
    w_wena_nx       = 1'b0;
    w_addr_nx       = r_addr;
    w_wdata_nx      = r_wdata;
    w_error_nx      = r_error;
    if (w_accept) begin
      case (r_state)
        S_IDLE, S_RUN: begin
          if (rx_data == MAGIC) begin
            w_state_nx = S_CNT_H;
            w_error_nx = 1'b0;
            w_csum_nx  = 8'h00;
          end
        end
        S_CNT_H: begin
          w_cnt_hi_nx = rx_data;
          w_csum_nx   = r_csum ^ rx_data;
          w_state_nx  = S_CNT_L;
        end
        S_CNT_L: begin
          w_csum_nx       = r_csum ^ rx_data;
          w_word_idx_nx   = '0;
          w_byte_idx_nx   = 2'd0;
          w_words_left_nx = w_count[ADDR_WIDTH:0];
          if ({1'b0, w_count} > MAX_WORDS) begin
            w_error_nx = 1'b1;
            w_state_nx = S_IDLE;
          end else if (w_count == 16'd0) begin
            w_state_nx = S_CSUM;
          end else begin
            w_state_nx = S_DATA;
          end
        end
        S_DATA: begin
          w_csum_nx     = r_csum ^ rx_data;
          w_asm_nx      = {r_asm[15:0], rx_data};
          w_byte_idx_nx = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_wena_nx       = 1'b1;
            w_addr_nx       = r_word_idx[ADDR_WIDTH-1:0];
            w_wdata_nx      = {r_asm, rx_data};
            w_word_idx_nx   = r_word_idx + ONE_WORD;
            w_words_left_nx = r_words_left - ONE_WORD;
            if (r_words_left == ONE_WORD) w_state_nx = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_data == r_csum) begin
            w_state_nx = S_RUN;
          end else begin
            w_error_nx = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
    // Flags are registered from the next state so they follow the accepting edge.
    w_busy_nx      = (w_state_nx == S_CNT_H) || (w_state_nx == S_CNT_L) ||
                     (w_state_nx == S_DATA)  || (w_state_nx == S_CSUM);
    w_done_nx      = (w_state_nx == S_RUN);
    w_cpu_rst_n_nx = (w_state_nx == S_RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_hi     <= 8'h00;
      r_words_left <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'h0;
      r_csum       <= 8'h00;
      r_rx_ready   <= 1'b0;
      r_wena       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_cnt_hi     <= w_cnt_hi_nx;
      r_words_left <= w_words_left_nx;
      r_word_idx   <= w_word_idx_nx;
      r_byte_idx   <= w_byte_idx_nx;
      r_asm        <= w_asm_nx;
      r_csum       <= w_csum_nx;
      r_rx_ready   <= 1'b1;
      r_wena       <= w_wena_nx;
      r_addr       <= w_addr_nx;
      r_wdata      <= w_wdata_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_cpu_rst_n  <= w_cpu_rst_n_nx;
      r_error      <= w_error_nx;
    end
  end

  assign rx_ready    = r_rx_ready;
  assign imem_wena   = r_wena;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign cpu_reset_n = r_cpu_rst_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame table, timing sequences, and random frames
// checked against a frame-level reference model.
module tb_imem_loader;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_wena, cpu_reset_n, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.ADDR_WIDTH(AW), .MAGIC(8'hA5)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_wena(imem_wena), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset_n(cpu_reset_n), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b[16];
    int         len;
    int         nwr;
    bit         done;
    bit         err;
  } vec_t;

  int              total = 0;
  int              bad = 0;
  logic [AW+31:0]  cap[$];
  logic [AW+31:0]  exp_w[$];
  bit              exp_done, exp_err;
  vec_t            vt[6];

  always @(negedge clock) if (imem_wena === 1'b1) cap.push_back({imem_addr, imem_wdata});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: locate MAGIC, decode count, slice words, XOR-check the frame.
  function automatic void model(input bq_t f);
    int i, cnt, p;
    logic [7:0]  x;
    logic [31:0] w;
    exp_w.delete();
    exp_done = 0;
    exp_err  = 0;
    i = 0;
    while (i < f.size() && f[i] != 8'hA5) i++;
    if (i + 2 >= f.size()) return;
    cnt = int'({f[i+1], f[i+2]});
    if (cnt > (1 << AW)) begin
      exp_err = 1;
      return;
    end
    if (i + 3 + 4*cnt >= f.size()) return;
    x = f[i+1] ^ f[i+2];
    for (int k = 0; k < cnt; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        p = i + 3 + 4*k + j;
        w = {w[23:0], f[p]};
        x = x ^ f[p];
      end
      exp_w.push_back({k[AW-1:0], w});
    end
    if (f[i+3+4*cnt] == x) exp_done = 1;
    else                   exp_err  = 1;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input bq_t f, input int gmax);
    cap.delete();
    model(f);
    foreach (f[k]) begin
      repeat ($urandom_range(0, gmax)) @(negedge clock);
      send(f[k]);
    end
    repeat (3) @(negedge clock);
    check({name, " nwr"}, cap.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < cap.size(); k++) begin
      check({name, " addr"}, 32'(cap[k][AW+31:32]), 32'(exp_w[k][AW+31:32]));
      check({name, " data"}, cap[k][31:0], exp_w[k][31:0]);
    end
    check({name, " done"}, 32'(done), 32'(exp_done));
    check({name, " error"}, 32'(error), 32'(exp_err));
    check({name, " cpu_reset_n"}, 32'(cpu_reset_n), 32'(exp_done));
    check({name, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic setv(input int i, input logic [127:0] p, input int len,
                      input int nwr, input bit d, input bit e);
    for (int k = 0; k < 16; k++) vt[i].b[k] = p[127-8*k -: 8];
    vt[i].len  = len;
    vt[i].nwr  = nwr;
    vt[i].done = d;
    vt[i].err  = e;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, " rx_ready"}, 32'(rx_ready), 32'd0);
    check({name, " wena"}, 32'(imem_wena), 32'd0);
    check({name, " addr"}, 32'(imem_addr), 32'd0);
    check({name, " wdata"}, imem_wdata, 32'd0);
    check({name, " cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
    check({name, " error"}, 32'(error), 32'd0);
  endtask

  initial begin
    bq_t         f;
    logic [15:0] cnt;
    logic [7:0]  x, b;

    setv(0, {96'hA50002200800053C01123434, 32'h0}, 12, 2, 1, 0);
    setv(1, {96'hA50002200800053C01123435, 32'h0}, 12, 2, 0, 1);
    setv(2, {32'hA5000000, 96'h0},                  4, 0, 1, 0);
    setv(3, {32'hA5040100, 96'h0},                  4, 0, 0, 1);
    setv(4, {120'h00FF13A50002200800053C01123434, 8'h0}, 15, 2, 1, 0);
    setv(5, {64'hA50001DEADBEEF23, 64'h0},          8, 1, 1, 0);

    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    check("ready after reset", 32'(rx_ready), 32'd1);

    // Write latency, release timing, reload.
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00);
    check("no early wena", 32'(imem_wena), 32'd0);
    send(8'h05);
    check("w0 wena", 32'(imem_wena), 32'd1);
    check("w0 addr", 32'(imem_addr), 32'd0);
    check("w0 data", imem_wdata, 32'h20080005);
    send(8'h3C); send(8'h01); send(8'h12); send(8'h34);
    check("w1 wena", 32'(imem_wena), 32'd1);
    check("w1 addr", 32'(imem_addr), 32'd1);
    check("w1 data", imem_wdata, 32'h3C011234);
    check("pre csum busy", 32'(busy), 32'd1);
    check("pre csum cpu", 32'(cpu_reset_n), 32'd0);
    send(8'h34);
    check("release cpu", 32'(cpu_reset_n), 32'd1);
    check("release done", 32'(done), 32'd1);
    check("release busy", 32'(busy), 32'd0);
    send(8'h00);
    check("run ignores", 32'(done), 32'd1);
    send(8'hA5);
    check("reload cpu", 32'(cpu_reset_n), 32'd0);
    check("reload done", 32'(done), 32'd0);
    check("reload busy", 32'(busy), 32'd1);
    send(8'h00); send(8'h00); send(8'h00);
    check("zero frame done", 32'(done), 32'd1);

    // Oversize count flags error right after the low count byte.
    send(8'hA5); send(8'h04); send(8'h01);
    check("oversize error", 32'(error), 32'd1);
    check("oversize busy", 32'(busy), 32'd0);
    send(8'h00);
    check("idle after oversize", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a frame.
    cap.delete();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05); send(8'h3C);
    reset = 1'b0;
    #1;
    check_zero_outputs("midframe reset");
    send(8'h01); send(8'h12); send(8'h34); send(8'h34);
    check("writes during reset", cap.size(), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Frame table, back-to-back then with random gaps.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 6; i++) begin
        f.delete();
        for (int k = 0; k < vt[i].len; k++) f.push_back(vt[i].b[k]);
        run_frame($sformatf("vec%0d", i), f, pass * 5);
        check($sformatf("vec%0d tbl nwr", i), cap.size(), vt[i].nwr);
        check($sformatf("vec%0d tbl done", i), 32'(done), 32'(vt[i].done));
        check($sformatf("vec%0d tbl error", i), 32'(error), 32'(vt[i].err));
      end
    end

    // Random frames with garbage prefix and occasional bad checksum.
    for (int r = 0; r < 10; r++) begin
      f.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        f.push_back(b == 8'hA5 ? 8'h00 : b);
      end
      cnt = 16'($urandom_range(0, 8));
      f.push_back(8'hA5);
      f.push_back(cnt[15:8]);
      f.push_back(cnt[7:0]);
      x = cnt[15:8] ^ cnt[7:0];
      for (int k = 0; k < 4 * int'(cnt); k++) begin
        b = 8'($urandom_range(0, 255));
        f.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
      f.push_back(x);
      run_frame($sformatf("rand%0d", r), f, 3);
    end

    // Largest legal frame, then one word over the limit.
    f.delete();
    f.push_back(8'hA5); f.push_back(8'h04); f.push_back(8'h00);
    x = 8'h04;
    for (int k = 0; k < 4 * (1 << AW); k++) begin
      b = 8'($urandom_range(0, 255));
      f.push_back(b);
      x = x ^ b;
    end
    f.push_back(x);
    run_frame("max frame", f, 0);
    check("max frame last addr", cap.size() > 0 ? 32'(cap[cap.size()-1][AW+31:32]) : 32'hFFFF_FFFF,
          32'((1 << AW) - 1));
    f.delete();
    f.push_back(8'hA5); f.push_back(8'h04); f.push_back(8'h01); f.push_back(8'h00);
    run_frame("max plus one", f, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
